// File: rtl/cmp_pkg.sv
// Shared encodings for the serial word comparator: FSM states, word result
// codes, and the legal digit-code check.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } res_t;

  // Legal only when exactly one of gt/eq/lt is set.
  function automatic logic onehot3_ok(input logic gt, input logic eq, input logic lt);
    return (gt & ~eq & ~lt) | (~gt & eq & ~lt) | (~gt & ~eq & lt);
  endfunction

endpackage

// File: rtl/cmp_code_check.sv
// Combinational check and encode of one digit comparator result (gt/eq/lt).
module cmp_code_check
  import cmp_pkg::*;
(
  input  logic dig_gt,
  input  logic dig_eq,
  input  logic dig_lt,
  output logic code_ok,
  output res_t code
);

  always_comb begin
    code_ok = onehot3_ok(dig_gt, dig_eq, dig_lt);
    code    = RES_EQ;
    if (dig_gt)      code = RES_GT;
    else if (dig_lt) code = RES_LT;
  end

endmodule

// File: rtl/serial_word_compare.sv
// Serial MSB-first word comparator: folds per-digit gt/eq/lt results into a
// word result, decided by the first unequal digit, with a one-cycle done pulse.
module serial_word_compare
  import cmp_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  dig_valid,
  input  logic                                  dig_gt,
  input  logic                                  dig_eq,
  input  logic                                  dig_lt,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  res_gt,
  output logic                                  res_eq,
  output logic                                  res_lt,
  output logic                                  err,
  output logic [((NDIGITS>1)?$clog2(NDIGITS):1)-1:0] dig_cnt
);

  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIGITS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_decided;
  res_t             r_acc;
  logic             r_err;
  logic             r_busy, r_done, r_res_gt, r_res_eq, r_res_lt;

  logic w_ok;
  res_t w_code;
  logic w_take;
  logic w_err_nxt, w_dec_nxt;
  res_t w_acc_nxt;

  cmp_code_check u_chk (
    .dig_gt  (dig_gt),
    .dig_eq  (dig_eq),
    .dig_lt  (dig_lt),
    .code_ok (w_ok),
    .code    (w_code)
  );

  // Post-digit view of the accumulator, so the last digit feeds the result directly.
  always_comb begin
    w_take    = ~r_decided & w_ok & (w_code != RES_EQ);
    w_err_nxt = r_err | ~w_ok;
    w_dec_nxt = r_decided | w_take;
    w_acc_nxt = w_take ? w_code : r_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_acc     <= RES_EQ;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_res_gt  <= 1'b0;
      r_res_eq  <= 1'b0;
      r_res_lt  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_acc     <= RES_EQ;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_res_gt  <= 1'b0;
            r_res_eq  <= 1'b0;
            r_res_lt  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (dig_valid) begin
            r_err     <= w_err_nxt;
            r_decided <= w_dec_nxt;
            r_acc     <= w_acc_nxt;
            if (r_cnt == LAST) begin
              r_state  <= ST_DONE;
              r_cnt    <= '0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_res_gt <= (w_acc_nxt == RES_GT) & ~w_err_nxt;
              r_res_lt <= (w_acc_nxt == RES_LT) & ~w_err_nxt;
              r_res_eq <= ~w_dec_nxt & ~w_err_nxt;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign res_gt  = r_res_gt;
  assign res_eq  = r_res_eq;
  assign res_lt  = r_res_lt;
  assign err     = r_err;
  assign dig_cnt = r_cnt;

endmodule

// File: tb/tb_serial_word_compare.sv
// Directed bench for serial_word_compare (NDIGITS=4); outputs sampled 1ns after posedge.
module tb_serial_word_compare;

  logic       clk = 1'b0;
  logic       rst, start, dig_valid, dig_gt, dig_eq, dig_lt;
  logic       busy, done, res_gt, res_eq, res_lt, err;
  logic [1:0] dig_cnt;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int t0;
  logic [5:0] obs;

  serial_word_compare #(.NDIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dig_valid(dig_valid),
    .dig_gt(dig_gt), .dig_eq(dig_eq), .dig_lt(dig_lt),
    .busy(busy), .done(done), .res_gt(res_gt), .res_eq(res_eq),
    .res_lt(res_lt), .err(err), .dig_cnt(dig_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // {busy, done, res_gt, res_eq, res_lt, err}
  assign obs = {busy, done, res_gt, res_eq, res_lt, err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic digit(input logic gt, input logic eq, input logic lt);
    dig_valid = 1'b1; dig_gt = gt; dig_eq = eq; dig_lt = lt;
    tick();
    dig_valid = 1'b0; dig_gt = 1'b0; dig_eq = 1'b0; dig_lt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dig_valid = 1'b0;
    dig_gt = 1'b0; dig_eq = 1'b0; dig_lt = 1'b0;
    tick(); tick();
    nvec++;
    if (obs !== 6'b000000 || dig_cnt !== 2'd0) begin
      nerr++; $display("FAIL reset_hold obs=%b cnt=%0d want obs=000000 cnt=0", obs, dig_cnt);
    end
    rst = 1'b0;
    tick(); tick();
    nvec++;
    if (obs !== 6'b000000 || dig_cnt !== 2'd0) begin
      nerr++; $display("FAIL reset_release obs=%b cnt=%0d want obs=000000 cnt=0", obs, dig_cnt);
    end
    // digits without start are ignored in IDLE
    digit(1'b1, 1'b0, 1'b0);
    nvec++;
    if (obs !== 6'b000000 || dig_cnt !== 2'd0) begin
      nerr++; $display("FAIL idle_digit obs=%b cnt=%0d want obs=000000 cnt=0", obs, dig_cnt);
    end
  endtask

  task automatic test_equal_word();
    t0 = cyc;
    do_start();
    nvec++;
    if (obs !== 6'b100000 || dig_cnt !== 2'd0) begin
      nerr++; $display("FAIL eq_started obs=%b cnt=%0d want obs=100000 cnt=0", obs, dig_cnt);
    end
    digit(1'b0, 1'b1, 1'b0);
    digit(1'b0, 1'b1, 1'b0);
    nvec++;
    if (dig_cnt !== 2'd2) begin
      nerr++; $display("FAIL eq_cnt got=%0d want=2", dig_cnt);
    end
    digit(1'b0, 1'b1, 1'b0);
    nvec++;
    if (obs !== 6'b100000) begin
      nerr++; $display("FAIL eq_not_early obs=%b want=100000", obs);
    end
    digit(1'b0, 1'b1, 1'b0);
    nvec++;
    if (obs !== 6'b010100 || dig_cnt !== 2'd0 || (cyc - t0) !== 5) begin
      nerr++; $display("FAIL eq_done obs=%b cnt=%0d lat=%0d want obs=010100 cnt=0 lat=5", obs, dig_cnt, cyc - t0);
    end
    tick(); tick();
    nvec++;
    if (obs !== 6'b000100) begin
      nerr++; $display("FAIL eq_hold obs=%b want=000100", obs);
    end
  endtask

  task automatic test_msb_decides();
    do_start();
    digit(1'b1, 1'b0, 1'b0);
    digit(1'b0, 1'b0, 1'b1);
    digit(1'b0, 1'b0, 1'b1);
    digit(1'b0, 1'b1, 1'b0);
    nvec++;
    if (obs !== 6'b011000) begin
      nerr++; $display("FAIL msb_gt obs=%b want=011000", obs);
    end
    tick();
    do_start();
    digit(1'b0, 1'b1, 1'b0);
    digit(1'b0, 1'b0, 1'b1);
    digit(1'b1, 1'b0, 1'b0);
    digit(1'b1, 1'b0, 1'b0);
    nvec++;
    if (obs !== 6'b010010) begin
      nerr++; $display("FAIL msb_lt obs=%b want=010010", obs);
    end
  endtask

  task automatic test_bubbles();
    tick();
    t0 = cyc;
    do_start();
    digit(1'b0, 1'b1, 1'b0);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    nvec++;
    if (obs !== 6'b100000 || dig_cnt !== 2'd1) begin
      nerr++; $display("FAIL bubble_hold obs=%b cnt=%0d want obs=100000 cnt=1", obs, dig_cnt);
    end
    digit(1'b0, 1'b0, 1'b1);
    digit(1'b1, 1'b0, 1'b0);
    digit(1'b0, 1'b1, 1'b0);
    nvec++;
    if (obs !== 6'b010010 || (cyc - t0) !== 8) begin
      nerr++; $display("FAIL bubble_done obs=%b lat=%0d want obs=010010 lat=8", obs, cyc - t0);
    end
  endtask

  task automatic test_illegal();
    tick();
    do_start();
    digit(1'b0, 1'b1, 1'b0);
    digit(1'b1, 1'b0, 1'b1);
    nvec++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      nerr++; $display("FAIL illegal_mid err=%b busy=%b want err=1 busy=1", err, busy);
    end
    digit(1'b1, 1'b0, 1'b0);
    digit(1'b0, 1'b1, 1'b0);
    nvec++;
    if (obs !== 6'b010001) begin
      nerr++; $display("FAIL illegal_done obs=%b want=010001", obs);
    end
    do_start();
    nvec++;
    if (obs !== 6'b100000) begin
      nerr++; $display("FAIL illegal_clear obs=%b want=100000", obs);
    end
    // no bit set on the last digit after a decided gt
    digit(1'b1, 1'b0, 1'b0);
    digit(1'b0, 1'b1, 1'b0);
    digit(1'b0, 1'b1, 1'b0);
    digit(1'b0, 1'b0, 1'b0);
    nvec++;
    if (obs !== 6'b010001) begin
      nerr++; $display("FAIL illegal_none obs=%b want=010001", obs);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    do_start();
    digit(1'b0, 1'b1, 1'b0);
    digit(1'b1, 1'b0, 1'b0);
    dig_valid = 1'b1; dig_lt = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; dig_valid = 1'b0; dig_lt = 1'b0;
    nvec++;
    if (obs !== 6'b000000 || dig_cnt !== 2'd0) begin
      nerr++; $display("FAIL mid_reset obs=%b cnt=%0d want obs=000000 cnt=0", obs, dig_cnt);
    end
    do_start();
    digit(1'b0, 1'b1, 1'b0);
    digit(1'b1, 1'b0, 1'b0);
    digit(1'b0, 1'b0, 1'b1);
    digit(1'b0, 1'b1, 1'b0);
    nvec++;
    if (obs !== 6'b011000) begin
      nerr++; $display("FAIL b2b_word1 obs=%b want=011000", obs);
    end
    do_start();
    nvec++;
    if (obs !== 6'b100000) begin
      nerr++; $display("FAIL b2b_restart obs=%b want=100000", obs);
    end
    digit(1'b0, 1'b0, 1'b1);
    digit(1'b1, 1'b0, 1'b0);
    digit(1'b0, 1'b1, 1'b0);
    digit(1'b1, 1'b0, 1'b0);
    nvec++;
    if (obs !== 6'b010010) begin
      nerr++; $display("FAIL b2b_word2 obs=%b want=010010", obs);
    end
    tick();
    nvec++;
    if (obs !== 6'b000010) begin
      nerr++; $display("FAIL b2b_pulse obs=%b want=000010", obs);
    end
  endtask

  initial begin
    test_reset();
    test_equal_word();
    test_msb_decides();
    test_bubbles();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
